// File: rtl/row_window_buffer.sv
// Row-window buffer: keeps the last DEPTH input rows and presents them as one
// flat window (row-major or column-major) with valid/ready on both sides.
module row_window_buffer #(
   parameter int PIX_W   = 8,
   parameter int ROW_PIX = 8,
   parameter int DEPTH   = 15,
   parameter int STRIDE  = 8,
   parameter int CNT_W   = 4
) (
   input  logic                             clock,
   input  logic                             reset_L,
   input  logic                             clear,
   input  logic                             transpose,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [ROW_PIX*PIX_W-1:0]         in_data,
   output logic                             win_valid,
   input  logic                             win_ready,
   output logic [DEPTH*ROW_PIX*PIX_W-1:0]   win_data,
   output logic [CNT_W-1:0]                 fill_cnt
);

   localparam int ROW_W = ROW_PIX * PIX_W;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] STRIDE_C = CNT_W'(STRIDE);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] need_q, need_d;
   logic [CNT_W-1:0] fill_q, fill_d;
   logic [ROW_W-1:0] slot_q [DEPTH];

   logic accept, consume;

   // clear masks both handshakes so a clearing cycle neither shifts nor consumes
   assign accept  = in_valid && in_ready && !clear;
   assign consume = (state_q == HOLD) && win_ready && !clear;

   always_comb begin
      state_d   = state_q;
      need_d    = need_q;
      fill_d    = fill_q;
      win_valid = (state_q == HOLD);
      in_ready  = reset_L && ((state_q == FILL) || win_ready);

      if (clear) begin
         state_d = FILL;
         need_d  = DEPTH_C;
         fill_d  = '0;
      end else begin
         if (accept && (fill_q != DEPTH_C))
            fill_d = fill_q + ONE_C;
         case (state_q)
            FILL: begin
               if (accept) begin
                  need_d = need_q - ONE_C;
                  if (need_q == ONE_C)
                     state_d = HOLD;
               end
            end
            HOLD: begin
               if (consume) begin
                  if (accept && (STRIDE == 1)) begin
                     state_d = HOLD;
                  end else if (accept) begin
                     state_d = FILL;
                     need_d  = STRIDE_C - ONE_C;
                  end else begin
                     state_d = FILL;
                     need_d  = STRIDE_C;
                  end
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= FILL;
         need_q  <= DEPTH_C;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         need_q  <= need_d;
         fill_q  <= fill_d;
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         for (int i = 0; i < DEPTH; i++)
            slot_q[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < DEPTH-1; i++)
            slot_q[i] <= slot_q[i+1];
         slot_q[DEPTH-1] <= in_data;
      end
   end

   // transpose only moves where a pixel lands; the source is always slot r, pixel p
   always_comb begin
      win_data = '0;
      for (int r = 0; r < DEPTH; r++) begin
         for (int p = 0; p < ROW_PIX; p++) begin
            if (transpose)
               win_data[(p*DEPTH+r)*PIX_W +: PIX_W] = slot_q[r][p*PIX_W +: PIX_W];
            else
               win_data[(r*ROW_PIX+p)*PIX_W +: PIX_W] = slot_q[r][p*PIX_W +: PIX_W];
         end
      end
   end

   assign fill_cnt = fill_q;

endmodule

// File: tb/tb_row_window_buffer.sv
// Bench for row_window_buffer: directed scenarios with literal expectations plus
// randomized traffic on a STRIDE=8 and a STRIDE=1 instance against a row-history model.
module tb_row_window_buffer;

   localparam int PIX_W = 8, ROW_PIX = 8, DEPTH = 15, CNT_W = 4;
   localparam int ROW_W = ROW_PIX * PIX_W;
   localparam int W     = DEPTH * ROW_W;

   logic clock = 1'b0;
   logic reset_L = 1'b0;
   always #5 clock = ~clock;

   logic             clr [2], tp [2], iv [2], wr [2], ir [2], wv [2];
   logic [ROW_W-1:0] id  [2];
   logic [W-1:0]     wd  [2];
   logic [CNT_W-1:0] fc  [2];

   int checks = 0;
   int errors = 0;

   row_window_buffer #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .DEPTH(DEPTH), .STRIDE(8), .CNT_W(CNT_W)) u8 (
      .clock(clock), .reset_L(reset_L), .clear(clr[0]), .transpose(tp[0]),
      .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
      .win_valid(wv[0]), .win_ready(wr[0]), .win_data(wd[0]), .fill_cnt(fc[0]));

   row_window_buffer #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .DEPTH(DEPTH), .STRIDE(1), .CNT_W(CNT_W)) u1 (
      .clock(clock), .reset_L(reset_L), .clear(clr[1]), .transpose(tp[1]),
      .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
      .win_valid(wv[1]), .win_ready(wr[1]), .win_data(wd[1]), .fill_cnt(fc[1]));

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         int b;
         b = 0;
         for (int i = DEPTH*ROW_PIX-1; i >= 0; i--)
            if (act[i*8 +: 8] !== exp[i*8 +: 8]) b = i;
         errors++;
         $display("FAIL %s: byte %0d got %0h expected %0h", nm, b, act[b*8 +: 8], exp[b*8 +: 8]);
      end
   endtask

   function automatic logic [ROW_W-1:0] row_k(input int k);
      return {ROW_PIX{8'(k)}};
   endfunction

   function automatic logic [W-1:0] win_rows(input int first);
      logic [W-1:0] w;
      w = '0;
      for (int r = 0; r < DEPTH; r++)
         for (int p = 0; p < ROW_PIX; p++)
            w[(r*ROW_PIX+p)*8 +: 8] = 8'(first + r);
      return w;
   endfunction

   function automatic int stride_of(input int d);
      return (d == 0) ? 8 : 1;
   endfunction

   // Model: history of accepted rows, rows seen since the last consume/clear/reset,
   // and how many of them are needed before the next window is shown.
   logic [ROW_W-1:0] m_slot [2][DEPTH];
   int m_since [2], m_target [2], m_fill [2];

   function automatic logic m_valid(input int d);
      return reset_L && (m_since[d] >= m_target[d]);
   endfunction

   always @(posedge clock or negedge reset_L) begin
      for (int d = 0; d < 2; d++) begin
         if (!reset_L) begin
            for (int j = 0; j < DEPTH; j++) m_slot[d][j] <= '0;
            m_since[d] <= 0; m_target[d] <= DEPTH; m_fill[d] <= 0;
         end else if (clr[d]) begin
            m_since[d] <= 0; m_target[d] <= DEPTH; m_fill[d] <= 0;
         end else begin
            logic v, rdy;
            int s, t;
            v   = m_since[d] >= m_target[d];
            rdy = v ? wr[d] : 1'b1;
            s   = (v && wr[d]) ? 0 : m_since[d];
            t   = (v && wr[d]) ? stride_of(d) : m_target[d];
            if (iv[d] && rdy) begin
               for (int j = 0; j < DEPTH-1; j++) m_slot[d][j] <= m_slot[d][j+1];
               m_slot[d][DEPTH-1] <= id[d];
               s = s + 1;
               m_fill[d] <= (m_fill[d] < DEPTH) ? m_fill[d] + 1 : DEPTH;
            end
            m_since[d] <= s; m_target[d] <= t;
         end
      end
   end

   always @(negedge clock) begin
      for (int d = 0; d < 2; d++) begin
         logic [W-1:0] ew;
         logic v;
         v  = m_valid(d);
         ew = '0;
         for (int r = 0; r < DEPTH; r++)
            for (int p = 0; p < ROW_PIX; p++)
               if (tp[d]) ew[(p*DEPTH+r)*8 +: 8] = m_slot[d][r][p*8 +: 8];
               else       ew[(r*ROW_PIX+p)*8 +: 8] = m_slot[d][r][p*8 +: 8];
         chk($sformatf("d%0d win_valid", d), W'(wv[d]), W'(v));
         chk($sformatf("d%0d in_ready", d), W'(ir[d]), W'(reset_L && (v ? wr[d] : 1'b1)));
         chk($sformatf("d%0d fill_cnt", d), W'(fc[d]), W'(m_fill[d]));
         chk($sformatf("d%0d win_data", d), wd[d], ew);
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [W-1:0] et, en;
      logic [ROW_W-1:0] rw;
      int nwin, run, best;
      for (int d = 0; d < 2; d++) begin
         clr[d] = 0; tp[d] = 0; iv[d] = 0; wr[d] = 0; id[d] = '0;
      end
      #3;
      chk("reset in_ready", W'(ir[0]), W'(0));
      chk("reset win_data", wd[0], '0);
      cyc();
      reset_L = 1'b1;
      #1;
      chk("release in_ready", W'(ir[0]), W'(1));

      // fill rows 1..15 with the consumer stalled
      iv[0] = 1;
      for (int k = 1; k <= 15; k++) begin id[0] = row_k(k); cyc(); end
      chk("fill win_valid", W'(wv[0]), W'(1));
      chk("fill fill_cnt", W'(fc[0]), W'(15));
      chk("fill in_ready", W'(ir[0]), W'(0));
      chk("fill window", wd[0], win_rows(1));

      // back-pressure: row 99 must not enter
      id[0] = row_k(99);
      repeat (5) cyc();
      chk("bp window", wd[0], win_rows(1));
      wr[0] = 1; id[0] = row_k(16);
      cyc();
      wr[0] = 0;
      chk("bp consume win_valid", W'(wv[0]), W'(0));
      for (int k = 17; k <= 23; k++) begin id[0] = row_k(k); cyc(); end
      chk("stride win_valid", W'(wv[0]), W'(1));
      chk("stride window", wd[0], win_rows(9));

      // clear with a simultaneous offered row
      iv[0] = 0; wr[0] = 1; cyc(); wr[0] = 0;
      clr[0] = 1; cyc(); clr[0] = 0;
      chk("clear fill_cnt", W'(fc[0]), W'(0));
      iv[0] = 1;
      for (int k = 30; k <= 39; k++) begin id[0] = row_k(k); cyc(); end
      clr[0] = 1; id[0] = row_k(40); cyc(); clr[0] = 0;
      chk("clear2 fill_cnt", W'(fc[0]), W'(0));
      for (int k = 41; k <= 54; k++) begin id[0] = row_k(k); cyc(); end
      chk("clear 14 rows win_valid", W'(wv[0]), W'(0));
      id[0] = row_k(55); cyc();
      chk("clear 15 rows win_valid", W'(wv[0]), W'(1));
      chk("clear window", wd[0], win_rows(41));

      // transpose layout
      iv[0] = 0; wr[0] = 1; cyc(); wr[0] = 0;
      clr[0] = 1; cyc(); clr[0] = 0;
      tp[0] = 1; iv[0] = 1;
      et = '0; en = '0;
      for (int r = 0; r < DEPTH; r++) begin
         for (int p = 0; p < ROW_PIX; p++) begin
            rw[p*8 +: 8] = {4'(r), 4'(p)};
            et[(p*DEPTH+r)*8 +: 8] = {4'(r), 4'(p)};
            en[(r*ROW_PIX+p)*8 +: 8] = {4'(r), 4'(p)};
         end
         id[0] = rw; cyc();
      end
      iv[0] = 0;
      chk("tp win_valid", W'(wv[0]), W'(1));
      chk("tp column-major", wd[0], et);
      wr[0] = 1; cyc(); wr[0] = 0;
      tp[0] = 0; #1;
      chk("tp row-major", wd[0], en);

      // asynchronous reset mid-fill
      iv[0] = 1;
      for (int k = 1; k <= 5; k++) begin id[0] = row_k(k); cyc(); end
      reset_L = 1'b0; #1;
      chk("midreset win_valid", W'(wv[0]), W'(0));
      chk("midreset fill_cnt", W'(fc[0]), W'(0));
      chk("midreset win_data", wd[0], '0);
      chk("midreset in_ready", W'(ir[0]), W'(0));
      iv[0] = 0;
      cyc(); cyc();
      reset_L = 1'b1; #1;
      chk("midrelease in_ready", W'(ir[0]), W'(1));

      // sliding window on the STRIDE=1 instance
      nwin = 0; run = 0; best = 0;
      wr[1] = 1;
      for (int k = 1; k <= 45; k++) begin
         iv[1] = (k <= 40);
         id[1] = row_k(k);
         cyc();
         if (wv[1]) begin
            nwin++; run++;
            if (run > best) best = run;
            chk("slide slot0", W'(wd[1][7:0]), W'(8'(nwin)));
            chk("slide slot14", W'(wd[1][W-1 -: 8]), W'(8'(nwin + 14)));
         end else run = 0;
      end
      chk("slide window count", W'(nwin), W'(26));
      chk("slide consecutive", W'(best), W'(26));
      iv[1] = 0; wr[1] = 0;

      // randomized traffic on both instances
      for (int c = 0; c < 3000; c++) begin
         if (reset_L && $urandom_range(0, 399) == 0) reset_L = 1'b0;
         else if (!reset_L && $urandom_range(0, 1) == 0) reset_L = 1'b1;
         for (int d = 0; d < 2; d++) begin
            iv[d]  = ($urandom_range(0, 3) != 0);
            wr[d]  = ($urandom_range(0, 2) != 0);
            clr[d] = ($urandom_range(0, 59) == 0);
            id[d]  = {$urandom, $urandom};
            if (!m_valid(d) && $urandom_range(0, 15) == 0) tp[d] = ~tp[d];
         end
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/row_window_buffer.md
# row_window_buffer

Parametrised row-window buffer feeding the HEVC 8-tap interpolation filters. It accepts one row of reference pixels per handshake and holds the most recent DEPTH rows, then presents them as a single flat window, row-major or transposed. A configurable stride sets how many new rows are needed between windows: 1 for a sliding window, 8 for block advance. Valid/ready handshakes on both sides let the block sit between the reference fetch unit and the vertical/horizontal filter stage with back-pressure.

## Interface
- PIX_W, 8, bits per pixel
- ROW_PIX, 8, pixels per input row
- DEPTH, 15, rows held in the window (taps + block − 1)
- STRIDE, 8, new rows required between consecutive windows; legal range 1..DEPTH
- CNT_W, 4, width of counters; must satisfy 2^CNT_W > DEPTH
- clock  in  1  rising-edge clock
- reset_L  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous restart of fill/state; storage contents untouched
- transpose  in  1  window layout select; quasi-static, change only while win_valid=0
- in_valid  in  1  in_data holds a valid row
- in_ready  out  1  buffer can accept a row this cycle
- in_data  in  ROW_PIX*PIX_W  row; pixel p at [p*PIX_W +: PIX_W]
- win_valid  out  1  win_data holds a complete window
- win_ready  in  1  consumer takes the window this cycle
- win_data  out  DEPTH*ROW_PIX*PIX_W  window, layout below
- fill_cnt  out  CNT_W  rows held since reset/clear, saturating at DEPTH

## Operation
- Storage is DEPTH row slots. Slot 0 is the oldest row and slot DEPTH-1 is the newest.
- Accept means in_valid && in_ready at a rising edge. On accept, every slot shifts down one (slot i ← slot i+1) and in_data loads into slot DEPTH-1.
- There is a need counter, `need`, of CNT_W bits.
- FSM states:
  - FILL: in_ready=1, win_valid=0. Each accept decrements `need`. An accept that brings `need` to 0 moves the FSM to HOLD.
  - HOLD: win_valid=1, in_ready=win_ready. A consume is win_ready=1 at an edge.
    - On consume with STRIDE=1 and a simultaneous accept: stay in HOLD with the new window.
    - On consume with STRIDE>1 and a simultaneous accept: go to FILL with `need`=STRIDE−1.
    - On consume without an accept: go to FILL with `need`=STRIDE.
  - With win_ready=0, HOLD is stable: storage is frozen and in_data is ignored.
- After reset or clear: state FILL, `need`=DEPTH, fill_cnt=0.
- fill_cnt increments on each accept and saturates at DEPTH.
- Layout with transpose=0: win_data[(r*ROW_PIX+p)*PIX_W +: PIX_W] = slot r, pixel p.
- Layout with transpose=1: win_data[(p*DEPTH+r)*PIX_W +: PIX_W] = slot r, pixel p. This is column-major, so each pixel column is contiguous for the horizontal filter.
- win_data is a combinational mux of registered storage and transpose. It is not registered again.
- clear takes priority over any handshake in the same cycle: no shift, no consume. After clear, win_data shows the stale storage, but win_valid=0.

## Timing
- All state updates on the rising clock edge.
- Async reset values: all slots 0, win_data 0, win_valid 0, fill_cnt 0, state FILL. in_ready is forced to 0 while reset_L=0.
- in_ready=1 from the first cycle after reset_L deasserts.
- Latency: win_valid rises in the cycle after the edge that accepts the row bringing `need` to 0.
- Throughput:
  - STRIDE=1 with in_valid and win_ready held high: one window per cycle after the initial DEPTH-row fill.
  - STRIDE=S: one window every S cycles.
- While win_valid=1 and win_ready=0, win_data, fill_cnt and in_ready=0 are stable for every cycle.
- Reset asserted mid-fill or mid-HOLD: the block returns to reset values immediately (asynchronously); partial rows are discarded.
- in_valid=1 while in_ready=0: the row is not taken. The source must hold it until accepted.

## Test plan
All scenarios use defaults (PIX_W=8, ROW_PIX=8, DEPTH=15, STRIDE=8) unless stated. Row k has every byte equal to k.
- Reset: assert reset_L=0 mid-stream → win_valid=0, fill_cnt=0, win_data=0 and in_ready=0 during reset; in_ready=1 in the first cycle after release.
- Fill: stream rows 1..15 with in_valid=1 and win_ready=0 → win_valid=1 in the cycle after the 15th accept; slot0 bytes=1, slot14 bytes=15; fill_cnt=15; in_ready=0.
- Back-pressure: hold win_ready=0 for 5 cycles while offering row 99 → win_data unchanged and row 99 not shifted in. Then pulse win_ready with in_valid=1 carrying row 16 → FILL with `need`=7; after rows 17..23 are accepted, window slot0=9, slot14=23.
- Transpose: load rows with pixel p of row r = {r[3:0],p[3:0]} and set transpose=1 → byte index p*15+r = {r,p} for all r, p. With transpose=0, byte index r*8+p matches the same value.
- Clear: assert clear after 10 accepts with in_valid=1 in the same cycle → fill_cnt=0 and that row is not taken; the next win_valid occurs only after 15 further accepts.
- Sliding: instance with STRIDE=1, rows 1..40 streamed, win_ready=1 → win_valid high on 26 consecutive cycles; window n has slot0=n, slot14=n+14.
